// File: rtl/sonar_scheduler.sv
// Round-robin time-of-flight sequencer: fires one ultrasonic sensor at a time, times its echo,
// converts it to centimetres and keeps the latest distance per channel.
module sonar_scheduler #(
   parameter int N_SENSORS  = 4,
   parameter int CLK_PER_US = 50,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int GUARD_US   = 60000,
   parameter int US_PER_CM  = 58,
   localparam int CW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [N_SENSORS-1:0]   echo,
   output logic [N_SENSORS-1:0]   trig,
   output logic                   busy,
   output logic                   meas_valid,
   output logic [CW-1:0]          meas_ch,
   output logic [8:0]             meas_dist,
   output logic                   meas_timeout,
   output logic [9*N_SENSORS-1:0] dist_flat
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_PER_US - 1);
   localparam logic [16:0]   TRIG_LAST  = 17'(TRIG_US - 1);
   localparam logic [16:0]   TMO_LAST   = 17'(TIMEOUT_US - 1);
   localparam logic [16:0]   GUARD_LAST = 17'(GUARD_US - 1);
   localparam logic [16:0]   GUARD_END  = 17'(GUARD_US);
   localparam logic [16:0]   CM_LAST    = 17'(US_PER_CM - 1);
   localparam logic [CW-1:0] CH_LAST    = CW'(N_SENSORS - 1);
   localparam logic [8:0]    CM_MAX     = 9'd511;

   typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GUARD} state_t;

   state_t state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [N_SENSORS-1:0] echo_s1_q, echo_s1_d, echo_s2_q, echo_s2_d, echo_d_q, echo_d_d;
   logic [PW-1:0] pre_q, pre_d, el_pre_q, el_pre_d, shot_pre_q, shot_pre_d;
   logic [16:0] us_q, us_d, el_us_q, el_us_d, shot_us_q, shot_us_d;
   logic [8:0] cm_q, cm_d;
   logic [N_SENSORS-1:0] trig_q, trig_d;
   logic busy_q, busy_d, meas_valid_q, meas_valid_d, meas_timeout_q, meas_timeout_d;
   logic [CW-1:0] meas_ch_q, meas_ch_d;
   logic [8:0] meas_dist_q, meas_dist_d;
   logic [9*N_SENSORS-1:0] dist_flat_q, dist_flat_d;

   logic tick, el_tick, shot_tick, el_done, guard_done, echo_sel, echo_rise;
   logic rec, rec_tmo, start;
   logic [8:0] rec_dist;

   assign tick       = (pre_q == PRE_MAX);
   assign el_tick    = (el_pre_q == PRE_MAX);
   assign shot_tick  = (shot_pre_q == PRE_MAX);
   // Fires on the clock that completes the last microsecond, so the result lands exactly on time.
   assign el_done    = el_tick && (el_us_q == TMO_LAST);
   assign guard_done = (shot_us_q == GUARD_END) || (shot_tick && (shot_us_q == GUARD_LAST));
   assign echo_sel   = echo_s2_q[ch_q];
   assign echo_rise  = echo_s2_q[ch_q] & ~echo_d_q[ch_q];

   always_comb begin
      echo_s1_d = echo;
      echo_s2_d = echo_s1_q;
      echo_d_d  = echo_s2_q;
      state_d   = state_q;
      ch_d      = ch_q;
      pre_d     = tick ? '0 : pre_q + 1'b1;
      us_d      = tick ? us_q + 17'd1 : us_q;
      el_pre_d  = el_tick ? '0 : el_pre_q + 1'b1;
      el_us_d   = el_tick ? el_us_q + 17'd1 : el_us_q;
      shot_pre_d = shot_pre_q;
      shot_us_d  = shot_us_q;
      if (shot_us_q != GUARD_END) begin
         shot_pre_d = shot_tick ? '0 : shot_pre_q + 1'b1;
         shot_us_d  = shot_tick ? shot_us_q + 17'd1 : shot_us_q;
      end
      cm_d     = cm_q;
      rec      = 1'b0;
      rec_tmo  = 1'b0;
      rec_dist = '0;
      start    = 1'b0;

      case (state_q)
         S_IDLE: if (enable) start = 1'b1;
         S_TRIG: begin
            if (tick && (us_q == TRIG_LAST)) begin
               state_d  = S_WAIT_RISE;
               pre_d    = '0;
               us_d     = '0;
               el_pre_d = '0;
               el_us_d  = '0;
            end
         end
         S_WAIT_RISE: begin
            if (echo_rise) begin
               state_d = S_MEASURE;
               pre_d   = '0;
               us_d    = '0;
               cm_d    = '0;
            end else if (el_done) begin
               rec      = 1'b1;
               rec_dist = CM_MAX;
               rec_tmo  = 1'b1;
            end
         end
         S_MEASURE: begin
            if (tick && (us_q == CM_LAST)) begin
               us_d = '0;
               if (cm_q != CM_MAX) cm_d = cm_q + 9'd1;
            end
            // Echo fall takes priority over a coincident timeout; the final cycle's count is included.
            if (!echo_sel) begin
               rec      = 1'b1;
               rec_dist = cm_d;
            end else if (el_done) begin
               rec      = 1'b1;
               rec_dist = CM_MAX;
               rec_tmo  = 1'b1;
            end
         end
         S_GUARD: begin
            if (guard_done) begin
               ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
               if (enable) start = 1'b1;
               else state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d    = S_TRIG;
         pre_d      = '0;
         us_d       = '0;
         shot_pre_d = '0;
         shot_us_d  = '0;
      end

      meas_valid_d   = rec;
      meas_ch_d      = meas_ch_q;
      meas_dist_d    = meas_dist_q;
      meas_timeout_d = meas_timeout_q;
      dist_flat_d    = dist_flat_q;
      if (rec) begin
         state_d        = S_GUARD;
         meas_ch_d      = ch_q;
         meas_dist_d    = rec_dist;
         meas_timeout_d = rec_tmo;
         dist_flat_d[int'(ch_q)*9 +: 9] = rec_dist;
      end

      trig_d = '0;
      if (state_d == S_TRIG) trig_d[ch_d] = 1'b1;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         ch_q           <= '0;
         echo_s1_q      <= '0;
         echo_s2_q      <= '0;
         echo_d_q       <= '0;
         pre_q          <= '0;
         us_q           <= '0;
         el_pre_q       <= '0;
         el_us_q        <= '0;
         shot_pre_q     <= '0;
         shot_us_q      <= '0;
         cm_q           <= '0;
         trig_q         <= '0;
         busy_q         <= 1'b0;
         meas_valid_q   <= 1'b0;
         meas_ch_q      <= '0;
         meas_dist_q    <= '0;
         meas_timeout_q <= 1'b0;
         dist_flat_q    <= '0;
      end else begin
         state_q        <= state_d;
         ch_q           <= ch_d;
         echo_s1_q      <= echo_s1_d;
         echo_s2_q      <= echo_s2_d;
         echo_d_q       <= echo_d_d;
         pre_q          <= pre_d;
         us_q           <= us_d;
         el_pre_q       <= el_pre_d;
         el_us_q        <= el_us_d;
         shot_pre_q     <= shot_pre_d;
         shot_us_q      <= shot_us_d;
         cm_q           <= cm_d;
         trig_q         <= trig_d;
         busy_q         <= busy_d;
         meas_valid_q   <= meas_valid_d;
         meas_ch_q      <= meas_ch_d;
         meas_dist_q    <= meas_dist_d;
         meas_timeout_q <= meas_timeout_d;
         dist_flat_q    <= dist_flat_d;
      end
   end

   assign trig         = trig_q;
   assign busy         = busy_q;
   assign meas_valid   = meas_valid_q;
   assign meas_ch      = meas_ch_q;
   assign meas_dist    = meas_dist_q;
   assign meas_timeout = meas_timeout_q;
   assign dist_flat    = dist_flat_q;

endmodule
